// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, decoded
// opcodes and the default memory wait budget.
package instruction_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    UPD  = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  localparam logic [5:0] OP_BR = 6'h04;
  localparam logic [5:0] OP_JR = 6'h08;

  localparam int DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/instruction_fetch_unit_branch_decode.sv
// Combinational decode of the captured instruction into the controls that
// steer the PC address generator (next-PC source, increment kind, offset).
module branch_decode
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] IR,
  output logic              PC_select,
  output logic              INC_select,
  output logic [ADDR_W-1:0] BranchOff
);

  logic [5:0]         w_opcode;
  logic [ADDR_W+17:0] w_off_ext;

  assign w_opcode  = IR[31:26];
  // Word offset becomes a byte offset: sign-extend the 16-bit immediate, then x4.
  assign w_off_ext = {{ADDR_W{IR[15]}}, IR[15:0], 2'b00};

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    PC_select  = 1'b1;
    INC_select = 1'b0;
    BranchOff  = '0;
    case (w_opcode)
      OP_BR: begin
        INC_select = 1'b1;
        BranchOff  = w_off_ext[ADDR_W-1:0];
      end
      OP_JR:   PC_select = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch controller: issues one memory read per fetch, captures the
// instruction, then drives a single PC update decoded from that instruction.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              fetch_go,
  input  logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] IR,
  output logic              IR_valid,
  output logic              PC_enable,
  output logic              PC_select,
  output logic              INC_select,
  output logic [ADDR_W-1:0] BranchOff,
  output logic              fetch_err
);

  localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic              w_pc_aligned;
  logic              w_dec_pc_sel;
  logic              w_dec_inc_sel;
  logic [ADDR_W-1:0] w_dec_boff;

  assign w_pc_aligned = (PC[1:0] == 2'b00);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (fetch_go && !stall) w_next = w_pc_aligned ? REQ : ERR;
      REQ:  w_next = WAIT;
      // A response on the final allowed cycle still wins over the timeout.
      WAIT: begin
        if (mem_ready)                    w_next = UPD;
        else if (r_wait_cnt == LAST_WAIT) w_next = ERR;
      end
      UPD: begin
        if (!stall) begin
          if (fetch_go) w_next = w_pc_aligned ? REQ : ERR;
          else          w_next = IDLE;
        end
      end
      ERR:     w_next = ERR;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ir_valid <= 1'b0;
      r_mem_rd   <= (w_next == WAIT);
      case (r_state)
        REQ: begin
          r_mem_addr <= PC;
          r_wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_ready) begin
            r_ir       <= mem_rdata;
            r_ir_valid <= 1'b1;
          end else if (r_wait_cnt != LAST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  branch_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_branch_decode (
    .IR         (r_ir),
    .PC_select  (w_dec_pc_sel),
    .INC_select (w_dec_inc_sel),
    .BranchOff  (w_dec_boff)
  );

  // Decoded PC controls are only exposed while the update is being applied.
  assign PC_enable  = (r_state == UPD) && !stall;
  assign PC_select  = (r_state == UPD) ? w_dec_pc_sel  : 1'b1;
  assign INC_select = (r_state == UPD) ? w_dec_inc_sel : 1'b0;
  assign BranchOff  = (r_state == UPD) ? w_dec_boff    : '0;
  assign fetch_err  = (r_state == ERR);
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;
  assign IR         = r_ir;
  assign IR_valid   = r_ir_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit: normal fetch,
// branch/jump decode, stall in UPD, timeout boundary, misalignment, reset.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        fetch_go;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] IR;
  logic        IR_valid;
  logic        PC_enable;
  logic        PC_select;
  logic        INC_select;
  logic [31:0] BranchOff;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .PC         (PC),
    .fetch_go   (fetch_go),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .IR         (IR),
    .IR_valid   (IR_valid),
    .PC_enable  (PC_enable),
    .PC_select  (PC_select),
    .INC_select (INC_select),
    .BranchOff  (BranchOff),
    .fetch_err  (fetch_err)
  );

  always #5 Clock = ~Clock;

  // Advance one edge; inputs changed afterwards are seen at the next edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Drive one fetch up to the first UPD cycle; ready comes after extra WAIT cycles.
  task automatic run_to_upd(input logic [31:0] pc, input logic [31:0] data, input int extra);
    PC       = pc;
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    repeat (extra) tick();
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({mem_addr, IR, BranchOff} !== 96'h0) begin n_fail++; $display("FAIL rst_words: got %h want 0", {mem_addr, IR, BranchOff}); end
    n_checks++; if ({mem_rd, IR_valid, PC_enable, PC_select, INC_select, fetch_err} !== 6'b000100) begin n_fail++; $display("FAIL rst_flags: got %b want 000100", {mem_rd, IR_valid, PC_enable, PC_select, INC_select, fetch_err}); end
  endtask

  task automatic test_basic_fetch();
    PC = 32'h100; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL s1_req: got rd=%b addr=%h want rd=1 addr=00000100", mem_rd, mem_addr); end
    tick();
    n_checks++; if ({mem_rd, IR_valid} !== 2'b10) begin n_fail++; $display("FAIL s1_wait: got rd/irv=%b want 10", {mem_rd, IR_valid}); end
    mem_ready = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    n_checks++; if ({mem_rd, IR_valid, PC_enable, PC_select, INC_select} !== 5'b01110) begin n_fail++; $display("FAIL s1_upd: got %b want 01110", {mem_rd, IR_valid, PC_enable, PC_select, INC_select}); end
    n_checks++; if (IR !== 32'h0) begin n_fail++; $display("FAIL s1_ir: got %h want 00000000", IR); end
    tick();
    n_checks++; if ({IR_valid, PC_enable} !== 2'b00) begin n_fail++; $display("FAIL s1_idle: got irv/pce=%b want 00", {IR_valid, PC_enable}); end
    // A response outside WAIT must not disturb IR.
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    mem_ready = 1'b0;
    n_checks++; if ({IR, IR_valid, mem_rd} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL stray_ready: got ir=%h irv=%b rd=%b want 0/0/0", IR, IR_valid, mem_rd); end
  endtask

  task automatic test_branch();
    run_to_upd(32'h200, 32'h1000_FFFE, 0);
    n_checks++; if ({PC_enable, PC_select, INC_select} !== 3'b111) begin n_fail++; $display("FAIL br_ctl: got %b want 111", {PC_enable, PC_select, INC_select}); end
    n_checks++; if (BranchOff !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL br_off: got %h want fffffff8", BranchOff); end
    tick();
    n_checks++; if ({INC_select, BranchOff} !== 33'h0) begin n_fail++; $display("FAIL br_default: got inc=%b off=%h want 0/0", INC_select, BranchOff); end
  endtask

  task automatic test_jump();
    run_to_upd(32'h204, 32'h2000_0000, 1);
    n_checks++; if ({PC_enable, PC_select, INC_select} !== 3'b100) begin n_fail++; $display("FAIL jr_ctl: got %b want 100", {PC_enable, PC_select, INC_select}); end
    // Chained fetch request with a misaligned PC from UPD goes to ERR.
    fetch_go = 1'b1; PC = 32'h203;
    tick();
    fetch_go = 1'b0;
    n_checks++; if ({fetch_err, mem_rd, PC_select} !== 3'b101) begin n_fail++; $display("FAIL upd_misalign: got err/rd/psel=%b want 101", {fetch_err, mem_rd, PC_select}); end
    do_reset();
  endtask

  task automatic test_stall_upd();
    run_to_upd(32'h300, 32'h1000_0003, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({PC_enable, BranchOff} !== {1'b0, 32'hC}) begin n_fail++; $display("FAIL stall_hold%0d: got pce=%b off=%h want 0/0000000c", i, PC_enable, BranchOff); end
      tick();
    end
    n_checks++; if (IR_valid !== 1'b0) begin n_fail++; $display("FAIL stall_irv: got %b want 0", IR_valid); end
    stall = 1'b0; fetch_go = 1'b1; PC = 32'h304;
    #1;
    n_checks++; if (PC_enable !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", PC_enable); end
    tick();
    fetch_go = 1'b0;
    n_checks++; if (PC_enable !== 1'b0) begin n_fail++; $display("FAIL stall_once: got %b want 0", PC_enable); end
    tick();
    PC = 32'h999;
    n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 32'h304}) begin n_fail++; $display("FAIL b2b_req: got rd=%b addr=%h want 1/00000304", mem_rd, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    n_checks++; if ({mem_addr, IR} !== {32'h304, 32'h1234_5678}) begin n_fail++; $display("FAIL b2b_hold: got addr=%h ir=%h want 00000304/12345678", mem_addr, IR); end
    tick();
  endtask

  task automatic test_last_wait_ready();
    PC = 32'h400; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    repeat (15) tick();
    n_checks++; if ({mem_rd, fetch_err} !== 2'b10) begin n_fail++; $display("FAIL last_wait: got rd/err=%b want 10", {mem_rd, fetch_err}); end
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ready = 1'b0;
    n_checks++; if ({IR_valid, fetch_err, IR} !== {2'b10, 32'h1111_1111}) begin n_fail++; $display("FAIL last_ready: got irv=%b err=%b ir=%h want 1/0/11111111", IR_valid, fetch_err, IR); end
    tick();
  endtask

  task automatic test_timeout();
    PC = 32'h500; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    repeat (15) tick();
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", fetch_err); end
    tick();
    n_checks++; if ({fetch_err, mem_rd, PC_enable} !== 3'b100) begin n_fail++; $display("FAIL to_err: got err/rd/pce=%b want 100", {fetch_err, mem_rd, PC_enable}); end
    fetch_go = 1'b1; mem_ready = 1'b1;
    repeat (5) tick();
    fetch_go = 1'b0; mem_ready = 1'b0;
    n_checks++; if ({fetch_err, mem_rd, IR_valid} !== 3'b100) begin n_fail++; $display("FAIL to_sticky: got err/rd/irv=%b want 100", {fetch_err, mem_rd, IR_valid}); end
    do_reset();
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", fetch_err); end
  endtask

  task automatic test_misaligned();
    PC = 32'h102; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    n_checks++; if ({fetch_err, mem_rd} !== 2'b10) begin n_fail++; $display("FAIL mis_err: got err/rd=%b want 10", {fetch_err, mem_rd}); end
    tick();
    n_checks++; if ({fetch_err, mem_rd} !== 2'b10) begin n_fail++; $display("FAIL mis_nord: got err/rd=%b want 10", {fetch_err, mem_rd}); end
    do_reset();
  endtask

  task automatic test_reset_in_wait();
    PC = 32'h600; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rw_wait: got %b want 1", mem_rd); end
    Reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_BABE;
    tick();
    Reset = 1'b0; mem_ready = 1'b0;
    n_checks++; if ({mem_addr, IR, BranchOff} !== 96'h0) begin n_fail++; $display("FAIL rw_words: got %h want 0", {mem_addr, IR, BranchOff}); end
    n_checks++; if ({mem_rd, IR_valid, PC_enable, PC_select, INC_select, fetch_err} !== 6'b000100) begin n_fail++; $display("FAIL rw_flags: got %b want 000100", {mem_rd, IR_valid, PC_enable, PC_select, INC_select, fetch_err}); end
  endtask

  initial begin
    Reset = 1'b1; PC = '0; fetch_go = 1'b0; stall = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_basic_fetch();
    test_branch();
    test_jump();
    test_stall_upd();
    test_last_wait_ready();
    test_timeout();
    test_misaligned();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
